gx_reconfig_rmw_master: RTL and testbench

GX_RECONFIG_RMW_MASTER -- requirements
Module: gx_reconfig_rmw_master

---
 rtl/gx_reconfig_rmw_master.sv | 128 ++++++++++++
 tb/tb_gx_reconfig_rmw_master.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gx_reconfig_rmw_master.sv
// gx_reconfig_rmw_master: read / write / read-modify-write master for the transceiver reconfig bus.
// Ports:
//   reconfig_clk, reconfig_reset         clock, synchronous active-high reset
//   req_valid/req_ready                  request handshake (ready only when idle)
//   req_op, req_channel, req_offset,     op 00 read, 01 write, 10 RMW, 11 reserved;
//   req_mask, req_data                   target channel/offset, RMW mask, write/insert data
//   rsp_valid, rsp_data, rsp_error       one-cycle response strobe with data and error flag
//   reconfig_read/write/address/
//   writedata/readdata/waitrequest       Avalon-MM master port
module gx_reconfig_rmw_master #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int NUM_CHANNELS   = 3
) (
    input  logic        reconfig_clk,
    input  logic        reconfig_reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [1:0]  req_channel,
    input  logic [9:0]  req_offset,
    input  logic [31:0] req_mask,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_error,
    output logic        reconfig_write,
    output logic        reconfig_read,
    output logic [11:0] reconfig_address,
    output logic [31:0] reconfig_writedata,
    input  logic [31:0] reconfig_readdata,
    input  logic        reconfig_waitrequest
);
    typedef enum logic [2:0] {IDLE, RD, MOD, WR, RSP} state_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    state_t        state;
    logic [1:0]    op;
    logic [31:0]   mask;
    logic [31:0]   data;
    logic [31:0]   rdata;
    logic [CW-1:0] stall;
    logic          timeout;
    // Abort on the stalled cycle that would bring the counter to TIMEOUT_CYCLES.
    assign timeout   = reconfig_waitrequest && stall == CW'(TIMEOUT_CYCLES - 1);
    assign req_ready = state == IDLE;
    always_ff @(posedge reconfig_clk) begin
        if (reconfig_reset) begin
            state              <= IDLE;
            stall              <= '0;
            op                 <= '0;
            mask               <= '0;
            data               <= '0;
            rdata              <= '0;
            reconfig_read      <= 1'b0;
            reconfig_write     <= 1'b0;
            reconfig_address   <= '0;
            reconfig_writedata <= '0;
            rsp_valid          <= 1'b0;
            rsp_error          <= 1'b0;
            rsp_data           <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    op               <= req_op;
                    mask             <= req_mask;
                    data             <= req_data;
                    reconfig_address <= {req_channel, req_offset};
                    stall            <= '0;
                    if (req_op == 2'b11 || int'(req_channel) >= NUM_CHANNELS) begin
                        state     <= RSP;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b1;
                        rsp_data  <= '0;
                    end else if (req_op == 2'b01) begin
                        reconfig_writedata <= req_data;
                        reconfig_write     <= 1'b1;
                        state              <= WR;
                    end else begin
                        reconfig_read <= 1'b1;
                        state         <= RD;
                    end
                end
                RD: if (!reconfig_waitrequest) begin
                    reconfig_read <= 1'b0;
                    rdata         <= reconfig_readdata;
                    if (op == 2'b10) begin
                        state <= MOD;
                    end else begin
                        state     <= RSP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= reconfig_readdata;
                    end
                end else if (timeout) begin
                    reconfig_read <= 1'b0;
                    state         <= RSP;
                    rsp_valid     <= 1'b1;
                    rsp_error     <= 1'b1;
                    rsp_data      <= '0;
                end else begin
                    stall <= stall + 1'b1;
                end
                MOD: begin
                    reconfig_writedata <= (rdata & ~mask) | (data & mask);
                    reconfig_write     <= 1'b1;
                    stall              <= '0;
                    state              <= WR;
                end
                WR: if (!reconfig_waitrequest) begin
                    reconfig_write <= 1'b0;
                    state          <= RSP;
                    rsp_valid      <= 1'b1;
                    rsp_data       <= reconfig_writedata;
                end else if (timeout) begin
                    reconfig_write <= 1'b0;
                    state          <= RSP;
                    rsp_valid      <= 1'b1;
                    rsp_error      <= 1'b1;
                    rsp_data       <= '0;
                end else begin
                    stall <= stall + 1'b1;
                end
                RSP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gx_reconfig_rmw_master.sv
// tb_gx_reconfig_rmw_master: table-driven bench for gx_reconfig_rmw_master with a stalling slave model.
module tb_gx_reconfig_rmw_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [1:0]  req_channel;
    logic [9:0]  req_offset;
    logic [31:0] req_mask;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_error;
    logic        wr;
    logic        rd;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        waitreq;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    gx_reconfig_rmw_master dut (
        .reconfig_clk(clk),
        .reconfig_reset(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_channel(req_channel),
        .req_offset(req_offset),
        .req_mask(req_mask),
        .req_data(req_data),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_error(rsp_error),
        .reconfig_write(wr),
        .reconfig_read(rd),
        .reconfig_address(addr),
        .reconfig_writedata(wdata),
        .reconfig_readdata(rdata),
        .reconfig_waitrequest(waitreq)
    );

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  ch;
        logic [9:0]  off;
        logic [31:0] mask;
        logic [31:0] data;
        logic [31:0] rdata;
        int          rd_wait;
        int          wr_wait;
        logic [11:0] exp_addr;
        logic [31:0] exp_wd;
        logic [31:0] exp_rsp;
        logic        exp_err;
        logic        chk_data;
        int          exp_reads;
        int          exp_writes;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run(input int idx, input vec_t v);
        int n = 1;
        int wl = 0;
        int rd_n = 0;
        int wr_n = 0;
        logic got = 1'b0;
        logic ov = 1'b0;
        logic addr_ok = 1'b1;
        logic prev_rd = 1'b0;
        logic prev_wr = 1'b0;
        logic [11:0] bad_addr = '0;
        logic [31:0] wd_seen = '0;
        @(negedge clk);
        chk($sformatf("v%0d_ready", idx), 32'(req_ready), 32'd1);
        req_op = v.op;
        req_channel = v.ch;
        req_offset = v.off;
        req_mask = v.mask;
        req_data = v.data;
        rdata = v.rdata;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        while (n <= 3000) begin
            if (rd && !prev_rd) wl = v.rd_wait;
            if (wr && !prev_wr) wl = v.wr_wait;
            if (rd) rd_n++;
            if (wr) begin
                wr_n++;
                wd_seen = wdata;
            end
            if ((rd || wr) && addr !== v.exp_addr) begin
                addr_ok = 1'b0;
                bad_addr = addr;
            end
            if (rd && wr) ov = 1'b1;
            waitreq = (rd || wr) && wl > 0;
            if (waitreq) wl--;
            prev_rd = rd;
            prev_wr = wr;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            n++;
        end
        waitreq = 1'b0;
        chk($sformatf("v%0d_rsp_seen", idx), 32'(got), 32'd1);
        if (v.chk_data) chk($sformatf("v%0d_rsp_data", idx), rsp_data, v.exp_rsp);
        chk($sformatf("v%0d_rsp_error", idx), 32'(rsp_error), 32'(v.exp_err));
        chk($sformatf("v%0d_latency", idx), 32'(n), 32'(v.exp_lat));
        chk($sformatf("v%0d_read_cycles", idx), 32'(rd_n), 32'(v.exp_reads));
        chk($sformatf("v%0d_write_cycles", idx), 32'(wr_n), 32'(v.exp_writes));
        if (v.exp_writes != 0) chk($sformatf("v%0d_writedata", idx), wd_seen, v.exp_wd);
        if (!addr_ok) chk($sformatf("v%0d_address", idx), 32'(bad_addr), 32'(v.exp_addr));
        else chk($sformatf("v%0d_address_ok", idx), 32'(addr_ok), 32'd1);
        chk($sformatf("v%0d_no_overlap", idx), 32'(ov), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_rsp_one_cycle", idx), 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int acc0 = -1;
        int acc1 = -1;
        int rsp0 = -1;
        int nacc = 0;
        int nrsp = 0;
        int stray = 0;
        logic pend = 1'b0;
        logic ov = 1'b0;
        logic [31:0] rsp1_data = '0;
        logic [31:0] b2b_wd = '0;
        vecs[0]  = '{2'b00, 2'd1, 10'h0AB, 32'h0, 32'h0, 32'hDEADBEEF, 2, 0,
                     12'h4AB, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 3, 0, 4};
        vecs[1]  = '{2'b10, 2'd2, 10'h010, 32'h000000F0, 32'h000000A0, 32'h12345678, 0, 0,
                     12'h810, 32'h123456A8, 32'h123456A8, 1'b0, 1'b1, 1, 1, 4};
        vecs[2]  = '{2'b01, 2'd0, 10'h3FF, 32'hFFFF0000, 32'hCAFEF00D, 32'h0, 0, 1,
                     12'h3FF, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b1, 0, 2, 3};
        vecs[3]  = '{2'b00, 2'd3, 10'h005, 32'h0, 32'h0, 32'h11111111, 0, 0,
                     12'h000, 32'h0, 32'h0, 1'b1, 1'b1, 0, 0, 1};
        vecs[4]  = '{2'b11, 2'd0, 10'h006, 32'h0, 32'h55, 32'h22222222, 0, 0,
                     12'h000, 32'h0, 32'h0, 1'b1, 1'b1, 0, 0, 1};
        vecs[5]  = '{2'b01, 2'd3, 10'h007, 32'h0, 32'h77, 32'h0, 0, 0,
                     12'h000, 32'h0, 32'h0, 1'b1, 1'b1, 0, 0, 1};
        vecs[6]  = '{2'b00, 2'd0, 10'h000, 32'h0, 32'h0, 32'h00000001, 0, 0,
                     12'h000, 32'h0, 32'h00000001, 1'b0, 1'b1, 1, 0, 2};
        vecs[7]  = '{2'b10, 2'd1, 10'h155, 32'hFFFF0000, 32'hABCD1234, 32'h11112222, 1, 2,
                     12'h555, 32'hABCD2222, 32'hABCD2222, 1'b0, 1'b1, 2, 3, 7};
        vecs[8]  = '{2'b01, 2'd2, 10'h001, 32'hFFFFFFFF, 32'h0, 32'h0, 0, 0,
                     12'h801, 32'h0, 32'h0, 1'b0, 1'b1, 0, 1, 2};
        vecs[9]  = '{2'b10, 2'd0, 10'h020, 32'h0, 32'hFFFFFFFF, 32'h5A5A5A5A, 0, 0,
                     12'h020, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0, 1'b1, 1, 1, 4};
        vecs[10] = '{2'b10, 2'd1, 10'h0AB, 32'hFFFFFFFF, 32'h1, 32'h0, 5000, 0,
                     12'h4AB, 32'h0, 32'h0, 1'b1, 1'b0, 1023, 0, 1024};
        vecs[11] = '{2'b00, 2'd2, 10'h3FF, 32'h0, 32'h0, 32'h87654321, 1022, 0,
                     12'hBFF, 32'h0, 32'h87654321, 1'b0, 1'b1, 1023, 0, 1024};
        vecs[12] = '{2'b01, 2'd0, 10'h100, 32'h0, 32'h00001234, 32'h0, 0, 5000,
                     12'h100, 32'h00001234, 32'h0, 1'b1, 1'b0, 0, 1023, 1024};
        rst = 1'b1;
        req_valid = 1'b0;
        req_op = '0;
        req_channel = '0;
        req_offset = '0;
        req_mask = '0;
        req_data = '0;
        rdata = '0;
        waitreq = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_read", 32'(rd), 32'd0);
        chk("reset_write", 32'(wr), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_error", 32'(rsp_error), 32'd0);
        chk("reset_address", 32'(addr), 32'd0);
        chk("reset_writedata", wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready_after", 32'(req_ready), 32'd1);

        for (int i = 0; i < 13; i++) run(i, vecs[i]);

        @(negedge clk);
        req_op = 2'b01;
        req_channel = 2'd1;
        req_offset = 10'h022;
        req_data = 32'h0F0F0F0F;
        req_valid = 1'b1;
        waitreq = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("midwr_write_on", 32'(wr), 32'd1);
        chk("midwr_address", 32'(addr), 32'h422);
        @(negedge clk);
        chk("midwr_write_held", 32'(wr), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midwr_write_off", 32'(wr), 32'd0);
        chk("midwr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midwr_address_clr", 32'(addr), 32'd0);
        chk("midwr_writedata_clr", wdata, 32'd0);
        rst = 1'b0;
        waitreq = 1'b0;
        @(negedge clk);
        chk("midwr_ready_after", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid || wr || rd) stray++;
            @(negedge clk);
        end
        chk("midwr_no_response", 32'(stray), 32'd0);

        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                req_op = 2'b01;
                req_channel = 2'd0;
                req_offset = 10'h011;
                req_data = 32'hAAAA5555;
                req_valid = 1'b1;
            end else if (pend) begin
                if (nacc == 1) begin
                    req_channel = 2'd2;
                    req_offset = 10'h3C0;
                    req_data = 32'h0000FFFF;
                end else begin
                    req_valid = 1'b0;
                end
                pend = 1'b0;
            end
            if (rd && wr) ov = 1'b1;
            if (wr && addr == 12'hBC0) b2b_wd = wdata;
            if (rsp_valid) begin
                if (nrsp == 0) rsp0 = i;
                else rsp1_data = rsp_data;
                nrsp++;
            end
            if (req_valid && req_ready) begin
                if (nacc == 0) acc0 = i;
                else acc1 = i;
                nacc++;
                pend = 1'b1;
            end
            @(negedge clk);
        end
        chk("b2b_accepts", 32'(nacc), 32'd2);
        chk("b2b_responses", 32'(nrsp), 32'd2);
        chk("b2b_first_accept", 32'(acc0), 32'd0);
        chk("b2b_first_rsp", 32'(rsp0), 32'd2);
        chk("b2b_second_accept", 32'(acc1), 32'(rsp0 + 1));
        chk("b2b_second_rsp_data", rsp1_data, 32'h0000FFFF);
        chk("b2b_second_writedata", b2b_wd, 32'h0000FFFF);
        chk("b2b_no_overlap", 32'(ov), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
